// File: rtl/ps2_mouse_packet_rx_if.sv
// Decoded mouse packet bus from the PS/2 receiver to the position accumulator.
interface ps2_mouse_packet_rx_if;
  logic       packet_valid;
  logic       left_button;
  logic       right_button;
  logic       middle_button;
  logic [8:0] dx;
  logic [8:0] dy;
  logic       x_ovf;
  logic       y_ovf;
  logic       frame_error;

  modport master (
    output packet_valid, left_button, right_button, middle_button,
           dx, dy, x_ovf, y_ovf, frame_error
  );
  modport slave (
    input  packet_valid, left_button, right_button, middle_button,
           dx, dy, x_ovf, y_ovf, frame_error
  );
endinterface

// File: rtl/ps2_mouse_packet_rx.sv
// PS/2 mouse receiver: pin sync, clock deglitch, 11-bit frame deserializer,
// 3-byte packet assembly and a stall watchdog.
module ps2_mouse_packet_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  ps2_clk,
  input  logic                  ps2_data,
  ps2_mouse_packet_rx_if.master pkt
);
  localparam int FW = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
  localparam int WW = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clk_sync, data_sync;
  logic          s_clk, s_data;
  logic          fclk, fclk_q, fall;
  logic [FW-1:0] fcnt;
  state_t        state, state_d;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          par_bit;
  logic          byte_ok, byte_bad;
  logic [1:0]    idx;
  logic [7:0]    byte0, byte1;
  logic [WW-1:0] wd;
  logic          busy, wd_fire;

  assign s_clk  = clk_sync[1];
  assign s_data = data_sync[1];
  assign fall   = fclk_q & ~fclk;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      fclk      <= 1'b1;
      fclk_q    <= 1'b1;
      fcnt      <= '0;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
      fclk_q    <= fclk;
      if (s_clk == fclk) begin
        fcnt <= '0;
      end else if (fcnt == FW'(FILTER_LEN - 1)) begin
        fclk <= s_clk;
        fcnt <= '0;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  // Edge beats watchdog on the same cycle, so the two error sources never double-pulse.
  assign busy    = (state != IDLE) || (idx != 2'd0);
  assign wd_fire = busy && !fall && (wd == WW'(TIMEOUT_CYCLES - 2));

  always_comb begin
    state_d  = state;
    byte_ok  = 1'b0;
    byte_bad = 1'b0;
    if (wd_fire) begin
      state_d = IDLE;
    end else if (fall) begin
      case (state)
        IDLE:    if (!s_data) state_d = DATA;
        DATA:    if (bit_idx == 3'd7) state_d = PARITY;
        PARITY:  state_d = STOP;
        STOP: begin
          state_d = IDLE;
          if (s_data && (^{shreg, par_bit})) byte_ok  = 1'b1;
          else                               byte_bad = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      bit_idx <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      state <= state_d;
      if (fall) begin
        case (state)
          IDLE:   bit_idx <= '0;
          DATA: begin
            shreg   <= {s_data, shreg[7:1]};
            bit_idx <= bit_idx + 1'b1;
          end
          PARITY: par_bit <= s_data;
          default: ;
        endcase
      end
    end
  end

  // Counter sits one below the limit when it fires: firing marks it reaching TIMEOUT_CYCLES-1.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                   wd <= '0;
    else if (fall || !busy || wd_fire) wd <= '0;
    else                           wd <= wd + 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      idx               <= '0;
      byte0             <= '0;
      byte1             <= '0;
      pkt.packet_valid  <= 1'b0;
      pkt.frame_error   <= 1'b0;
      pkt.left_button   <= 1'b0;
      pkt.right_button  <= 1'b0;
      pkt.middle_button <= 1'b0;
      pkt.dx            <= '0;
      pkt.dy            <= '0;
      pkt.x_ovf         <= 1'b0;
      pkt.y_ovf         <= 1'b0;
    end else begin
      pkt.packet_valid <= 1'b0;
      pkt.frame_error  <= 1'b0;
      if (wd_fire || byte_bad) begin
        idx             <= '0;
        pkt.frame_error <= 1'b1;
      end else if (byte_ok) begin
        case (idx)
          2'd0: if (shreg[3]) begin
            byte0 <= shreg;
            idx   <= 2'd1;
          end
          2'd1: begin
            byte1 <= shreg;
            idx   <= 2'd2;
          end
          default: begin
            idx               <= '0;
            pkt.packet_valid  <= 1'b1;
            pkt.left_button   <= byte0[0];
            pkt.right_button  <= byte0[1];
            pkt.middle_button <= byte0[2];
            pkt.dx            <= {byte0[4], byte1};
            pkt.dy            <= {byte0[5], shreg};
            pkt.x_ovf         <= byte0[6];
            pkt.y_ovf         <= byte0[7];
          end
        endcase
      end
    end
  end
endmodule
